// File: rtl/tms_loader_pkg.sv
// Shared definitions for the TMS1x00 program-memory loader.
// Holds the register map offsets (word index, i.e. adr[7:2]),
// CTRL/STATUS bit positions, FSM state encoding, handoff length
// and the CRC-8 byte update used when TMS_LOADER_CRC_EN is defined.
// No ports: this is a package imported by the loader and its CRC unit.
package tms_loader_pkg;

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_ADDR   = 6'h02;
  localparam logic [5:0] OFF_DATA   = 6'h03;
  localparam logic [5:0] OFF_CRC    = 6'h04;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_TMS1100   = 1;
  localparam int STAT_RUN       = 0;
  localparam int STAT_CPU_RST_N = 1;
  localparam int STAT_WR_REJECT = 2;

  localparam logic [7:0] CRC_POLY       = 8'h07;
  localparam int         HANDOFF_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_MEM_WAIT,
    ST_ACK,
    ST_HANDOFF
  } state_t;

  // Folds one byte into a CRC-8 (MSB first, no reflection, no final xor).
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/tms_wb_progmem_loader_crc8.sv
// CRC-8 accumulator over bytes accepted into program memory.
// Only instantiated when TMS_LOADER_CRC_EN is defined.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clear      : zero the running CRC (takes priority over update)
//   update     : fold 'data' into the running CRC this cycle
//   data       : byte being written to program memory
//   crc        : current CRC value
module tms_crc8
  import tms_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       update,
  input  logic [7:0] data,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  // Running CRC register; a pointer reload restarts the checksum so the
  // firmware can checksum each block it loads from the new start address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= 8'h00;
    end else if (clear) begin
      crc_q <= 8'h00;
    end else if (update) begin
      crc_q <= crc8_byte(crc_q, data);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/tms_wb_progmem_loader.sv
// Wishbone slave in front of the TMS1x00 core. While the CPU is held in
// reset the management core loads/verifies program memory through an
// auto-incrementing pointer; setting CTRL.run hands the memory port to
// the CPU and releases its reset after a short handoff delay.
// Optional build macro: TMS_LOADER_CRC_EN adds a CRC-8 of written bytes
// readable at offset 0x10 (reads 0 when the macro is undefined).
// Ports:
//   wb_clk_i, wb_rst_n      : clock, asynchronous active-low reset
//   wbs_*                   : Wishbone slave (cyc/stb/we/sel/adr/dat in,
//                             ack/dat out)
//   mem_en_o/we_o/addr_o/
//   mem_wdata_o/mem_rdata_i : program memory port (read data 1 cycle
//                             after mem_en_o)
//   cpu_addr_i, cpu_en_i    : CPU fetch request, forwarded while running
//   cpu_rst_n_o             : CPU reset, active-low
//   tms1100_o               : core variant select (CTRL bit1)
module tms_wb_progmem_loader
  import tms_loader_pkg::*;
#(
  parameter int          ADDR_W    = 11,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic              cpu_en_i,
  output logic              cpu_rst_n_o,
  output logic              tms1100_o
);

  localparam logic [ADDR_W-1:0] MASK_TMS1000 = ADDR_W'(1023);
  localparam logic [ADDR_W-1:0] MASK_TMS1100 = '1;
  localparam logic [1:0]        HANDOFF_LAST = 2'(HANDOFF_CYCLES - 1);

  state_t            state_q, state_d;
  logic              run_q, tms_q, wr_reject_q, cpu_rst_n_q, handoff_pend_q;
  logic [1:0]        hoff_cnt_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [31:0]       dat_q;
  logic [31:0]       reg_rdata;
  logic [7:0]        crc_val;

  logic              hit, accept, is_data, data_rd, reg_wr;
  logic              data_wr_ok, addr_wr, handoff_done;
  logic [5:0]        offset;
  logic [ADDR_W-1:0] ptr_mask, ptr_inc;
  logic              unused_bits;

  assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign offset  = wbs_adr_i[7:2];
  assign accept  = (state_q == ST_IDLE) & hit;
  assign is_data = (offset == OFF_DATA);
  assign data_rd = accept & is_data & ~wbs_we_i;
  // Writes of any kind only act when the low byte lane is selected.
  assign reg_wr     = accept & wbs_we_i & wbs_sel_i[0];
  assign data_wr_ok = reg_wr & is_data & ~run_q;
  assign addr_wr    = reg_wr & (offset == OFF_ADDR);

  // The TMS1000 has a 1 KiB program space, so the pointer wraps there
  // unless the TMS1100 variant is selected.
  assign ptr_mask = tms_q ? MASK_TMS1100 : MASK_TMS1000;
  assign ptr_inc  = (ptr_q + ADDR_W'(1)) & ptr_mask;

  assign handoff_done = (state_q == ST_HANDOFF) && (hoff_cnt_q == HANDOFF_LAST);

  assign unused_bits = &{1'b0, wbs_adr_i[1:0], wbs_sel_i[3:1], wbs_dat_i[31:ADDR_W]};

  // State register for the access sequencer.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: only IDLE accepts a new hit, so accesses are fully
  // serialised. DATA reads take the two-cycle memory detour before ACK;
  // a run 0->1 write detours through HANDOFF after its ACK.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (hit) state_d = (is_data && !wbs_we_i) ? ST_MEM_RD : ST_ACK;
      ST_MEM_RD:   state_d = ST_MEM_WAIT;
      ST_MEM_WAIT: state_d = ST_ACK;
      ST_ACK:      state_d = handoff_pend_q ? ST_HANDOFF : ST_IDLE;
      ST_HANDOFF:  if (handoff_done) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Register read mux, sampled into the read-data register on accept.
  always_comb begin
    reg_rdata = '0;
    case (offset)
      OFF_CTRL: begin
        reg_rdata[CTRL_RUN]     = run_q;
        reg_rdata[CTRL_TMS1100] = tms_q;
      end
      OFF_STATUS: begin
        reg_rdata[STAT_RUN]       = run_q;
        reg_rdata[STAT_CPU_RST_N] = cpu_rst_n_q;
        reg_rdata[STAT_WR_REJECT] = wr_reject_q;
      end
      OFF_ADDR: reg_rdata[ADDR_W-1:0] = ptr_q;
      OFF_CRC:  reg_rdata[7:0]        = crc_val;
      default:  reg_rdata = '0;
    endcase
  end

  // Register file and handoff sequencing. Register side effects happen on
  // the accept edge; DATA reads advance the pointer once the byte is
  // captured. CPU reset drops on the same edge run clears but only rises
  // when the handoff delay has elapsed.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      run_q          <= 1'b0;
      tms_q          <= 1'b0;
      wr_reject_q    <= 1'b0;
      cpu_rst_n_q    <= 1'b0;
      handoff_pend_q <= 1'b0;
      hoff_cnt_q     <= 2'd0;
      ptr_q          <= '0;
      dat_q          <= 32'h0;
    end else begin
      if (state_q == ST_HANDOFF) begin
        hoff_cnt_q <= hoff_cnt_q + 2'd1;
      end
      if (handoff_done) begin
        cpu_rst_n_q    <= 1'b1;
        handoff_pend_q <= 1'b0;
        hoff_cnt_q     <= 2'd0;
      end
      if (accept && !data_rd) begin
        dat_q <= wbs_we_i ? 32'h0 : reg_rdata;
      end
      if (reg_wr) begin
        case (offset)
          OFF_CTRL: begin
            run_q <= wbs_dat_i[CTRL_RUN];
            tms_q <= wbs_dat_i[CTRL_TMS1100];
            if (!run_q && wbs_dat_i[CTRL_RUN]) handoff_pend_q <= 1'b1;
            if (run_q && !wbs_dat_i[CTRL_RUN]) cpu_rst_n_q <= 1'b0;
          end
          OFF_STATUS: if (wbs_dat_i[STAT_WR_REJECT]) wr_reject_q <= 1'b0;
          OFF_ADDR:   ptr_q <= wbs_dat_i[ADDR_W-1:0] & ptr_mask;
          OFF_DATA: begin
            if (run_q) wr_reject_q <= 1'b1;
            else       ptr_q       <= ptr_inc;
          end
          default: ;
        endcase
      end
      if (state_q == ST_MEM_WAIT) begin
        dat_q <= run_q ? 32'h0 : {24'h0, mem_rdata_i};
        if (!run_q) ptr_q <= ptr_inc;
      end
    end
  end

  // Memory port ownership: the loader drives it while the CPU is held,
  // the CPU fetch port (read-only) once running. Write data is gated so
  // the bus stays quiet outside a write strobe.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 8'h00;
    if (run_q) begin
      mem_en_o   = cpu_en_i;
      mem_addr_o = cpu_addr_i;
    end else begin
      mem_en_o   = data_wr_ok | (state_q == ST_MEM_RD);
      mem_we_o   = data_wr_ok;
      mem_addr_o = ptr_q;
      if (data_wr_ok) mem_wdata_o = wbs_dat_i[7:0];
    end
  end

`ifdef TMS_LOADER_CRC_EN
  tms_crc8 u_crc8 (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n),
    .clear  (addr_wr),
    .update (data_wr_ok),
    .data   (wbs_dat_i[7:0]),
    .crc    (crc_val)
  );
`else
  assign crc_val = 8'h00;
`endif

  assign wbs_ack_o   = (state_q == ST_ACK);
  assign wbs_dat_o   = dat_q;
  assign cpu_rst_n_o = cpu_rst_n_q;
  assign tms1100_o   = tms_q;

endmodule

// File: doc/tms_wb_progmem_loader.md
Name: tms_wb_progmem_loader

Overview:
- Wishbone slave that sits directly upstream of the TMS1x00 core in the user project.
- Lets the management core load and verify program memory byte by byte while the CPU is held in reset.
- Hands the memory port to the CPU and releases CPU reset on command.
- The management firmware uses it for the "write program memory / verify program memory / run" sequence.

Parameters:
- ADDR_W, 11, program memory address width (2048 bytes max).
- BASE_ADDR, 32'h3000_0000, Wishbone base address; bits [31:8] are decoded.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_n  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- mem_en_o  out  1  memory enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  8  memory write data
- mem_rdata_i  in  8  memory read data, 1-cycle latency after mem_en_o
- cpu_addr_i  in  ADDR_W  CPU fetch address
- cpu_en_i  in  1  CPU fetch enable
- cpu_rst_n_o  out  1  CPU reset, active-low
- tms1100_o  out  1  core variant select

Behaviour:
- Reset state (async, wb_rst_n=0):
  - wbs_ack_o=0, wbs_dat_o=0, mem_en_o=0, mem_we_o=0.
  - cpu_rst_n_o=0, tms1100_o=0.
  - CTRL=0, ADDR=0, wr_reject=0, FSM=IDLE.
  - A reset mid-transaction aborts with no ack.
- Address decode: hit = cyc & stb & (adr[31:8]==BASE_ADDR[31:8]); offset = adr[7:2]. Register map:
  - 0x00 CTRL: bit0 run, bit1 tms1100.
  - 0x04 STATUS: bit0 run, bit1 cpu_rst_n_o, bit2 wr_reject (write 1 to clear).
  - 0x08 ADDR: pointer.
  - 0x0C DATA: memory access with ADDR auto-increment.
  - 0x10 CRC.
- Register writes take effect only when sel[0]=1.
- Unmapped offsets: ack, read 0, writes ignored. Non-hit: no ack.
- FSM states: IDLE, MEM_RD, MEM_WAIT, ACK, HANDOFF.
  - IDLE→ACK on any hit except a DATA read; the register action is performed on that edge.
  - DATA read: IDLE→MEM_RD (mem_en=1, we=0) → MEM_WAIT (capture mem_rdata_i into dat_o[7:0]) → ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle, then IDLE. A new hit is not accepted in the ACK cycle.
  - Latency: register access acks 1 cycle after the hit is sampled; DATA read acks 3 cycles after.
- DATA write with run=0:
  - mem_en=mem_we=1 for one cycle, mem_wdata=dat_i[7:0], mem_addr=ADDR.
  - ADDR increments.
- DATA write with run=1: memory untouched, ADDR unchanged, wr_reject set, still acked.
- DATA read with run=1: returns 0, ADDR unchanged.
- ADDR wrap: increments modulo 1024 when tms1100=0, modulo 2^ADDR_W when tms1100=1. Writing ADDR masks it the same way.
- Memory mux: run=0 drives the loader signals; run=1 forwards cpu_addr_i and cpu_en_i with we=0.
- Handoff:
  - run 0→1: ACK → HANDOFF (2 cycles) → IDLE. cpu_rst_n_o rises on the HANDOFF exit edge.
  - run 1→0: cpu_rst_n_o falls on the same edge run clears.
  - Writing run with its current value: no handoff, no change.
- tms1100_o mirrors CTRL bit1.
- A write to STATUS bit2 and a rejected DATA write never occur in the same cycle, since accesses are serialised.

Optional Feature:
- Macro: TMS_LOADER_CRC_EN.
- Defined:
  - CRC-8 (poly 0x07, init 0x00, MSB-first) updated with each accepted DATA write byte.
  - Cleared by any ADDR write.
  - Readable at 0x10 in bits [7:0].
- Undefined: no CRC logic; 0x10 reads 0.

Decomposition:
- Shared package/include tms_loader_pkg:
  - Register offsets and CTRL/STATUS bit indices.
  - FSM state encodings.
  - CRC_POLY, HANDOFF_CYCLES=2.
- One sub-module, tms_crc8 (combinational byte update plus register), instantiated only under TMS_LOADER_CRC_EN.

Test Plan:
- Write ADDR=0x000, DATA 0xA5, 0x3C; write ADDR=0 and read DATA twice → 0xA5, 0x3C. Each read acks 3 cycles after stb; ADDR reads back 2.
- tms1100=0, ADDR=0x3FF, write DATA → mem_addr_o=0x3FF, ADDR reads 0x000. With tms1100=1, the same sequence yields ADDR 0x400.
- Write CTRL=1 → cpu_rst_n_o stays 0 through 2 cycles after ack, then 1. mem_addr_o follows cpu_addr_i=0x123. Write CTRL=0 → cpu_rst_n_o=0 on the same edge.
- run=1, write DATA 0x55 → no mem_we_o, STATUS=0x7. Write STATUS=0x4 → STATUS=0x3.
- Assert wb_rst_n=0 during MEM_WAIT → no ack, all outputs 0. A fresh DATA read after release is acked normally.
- With TMS_LOADER_CRC_EN: write ADDR=0, DATA 0x01, 0x02 → CRC reads 0x1B. Without the macro → 0x00.
